// File: rtl/boton_acondicionador.sv
// ---------------------------------------------------------------------------
// boton_acondicionador
//
// Conditions the three raw push buttons of the order menu (next, back,
// cancel). Each channel is polarity-corrected, synchronised through two
// flip-flops and debounced. Every debounced press (0->1 acceptance) becomes
// exactly one single-cycle pulse. At most one pulse is high in any cycle.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive cycles of disagreement before the level is
//                     accepted (2 .. 2**CNT_W-1)
//   CNT_W           : width of each debounce counter
//   ACTIVE_LOW      : 1 -> raw buttons read 0 when pressed
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   btn_sig_raw  in   raw "next" button (asynchronous)
//   btn_reg_raw  in   raw "back" button (asynchronous)
//   btn_can_raw  in   raw "cancel" button (asynchronous)
//   siguiente    out  registered one-cycle pulse for "next"
//   regresar     out  registered one-cycle pulse for "back"
//   cancelar     out  registered one-cycle pulse for "cancel"
//   pending      out  accepted presses not yet emitted, {can, reg, sig}
// ---------------------------------------------------------------------------
module boton_acondicionador #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_sig_raw,
  input  logic       btn_reg_raw,
  input  logic       btn_can_raw,
  output logic       siguiente,
  output logic       regresar,
  output logic       cancelar,
  output logic [2:0] pending
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  // Channel bit order everywhere: {can, reg, sig}; bit 2 has top priority.
  logic [2:0]       w_raw;
  logic [2:0]       w_pol;
  logic [2:0]       w_accept;
  logic [2:0]       w_grant;

  logic [2:0]       r_s1;
  logic [2:0]       r_s2;
  logic [2:0]       r_stable;
  logic [CNT_W-1:0] r_cnt [3];
  logic [2:0]       r_pending;
  logic [2:0]       r_pulse;

  assign w_raw = {btn_can_raw, btn_reg_raw, btn_sig_raw};
  assign w_pol = ACTIVE_LOW ? ~w_raw : w_raw;

  // Two-flop synchroniser; reset to the released level so a button held
  // through reset is seen as a fresh press once reset lifts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_pol;
      r_s2 <= r_s1;
    end
  end

  // Acceptance edge where the debounced level rises: this is a press.
  always_comb begin
    w_accept = '0;
    for (int c = 0; c < 3; c++) begin
      w_accept[c] = (r_s2[c] != r_stable[c]) && (r_cnt[c] == LP_CNT_LAST) && r_s2[c];
    end
  end

  // Debounce: the counter only runs while s2 disagrees with the accepted
  // level, so any agreeing sample restarts it and it can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable <= '0;
      for (int c = 0; c < 3; c++) begin
        r_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (r_s2[c] == r_stable[c]) begin
          r_cnt[c] <= '0;
        end else if (r_cnt[c] == LP_CNT_LAST) begin
          r_stable[c] <= r_s2[c];
          r_cnt[c]    <= '0;
        end else begin
          r_cnt[c] <= r_cnt[c] + LP_CNT_ONE;
        end
      end
    end
  end

  // Fixed priority pick: cancel > back > next.
  always_comb begin
    w_grant = '0;
    if (r_pending[2]) begin
      w_grant = 3'b100;
    end else if (r_pending[1]) begin
      w_grant = 3'b010;
    end else if (r_pending[0]) begin
      w_grant = 3'b001;
    end
  end

  // The served bit is cleared before the new accepts are OR-ed in, so a
  // press accepted on the same edge its bit is served stays pending and
  // yields a second pulse; a press on an already-pending bit merges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_pulse   <= '0;
    end else begin
      r_pending <= (r_pending & ~w_grant) | w_accept;
      r_pulse   <= w_grant;
    end
  end

  assign siguiente = r_pulse[0];
  assign regresar  = r_pulse[1];
  assign cancelar  = r_pulse[2];
  assign pending   = r_pending;

endmodule

// File: tb/tb_boton_acondicionador.sv
// ---------------------------------------------------------------------------
// tb_boton_acondicionador
//
// Two instances share one logical stimulus: dut_h sees the buttons
// active-high (ACTIVE_LOW=0), dut_l sees the inverted levels with
// ACTIVE_LOW=1. Both must behave identically and match a reference model
// that works from the "last N synchronised samples all disagree" rule and a
// pending-set served highest channel first.
// ---------------------------------------------------------------------------
module tb_boton_acondicionador;

  localparam int N     = 4;
  localparam int CNT_W = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] press = 3'b000;
  logic [2:0] press_n;
  assign press_n = ~press;

  logic       sig_h, reg_h, can_h;
  logic [2:0] pend_h;
  logic       sig_l, reg_l, can_l;
  logic [2:0] pend_l;

  boton_acondicionador #(.DEBOUNCE_CYCLES(N), .CNT_W(CNT_W), .ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .reset(reset),
    .btn_sig_raw(press[0]), .btn_reg_raw(press[1]), .btn_can_raw(press[2]),
    .siguiente(sig_h), .regresar(reg_h), .cancelar(can_h), .pending(pend_h)
  );

  boton_acondicionador #(.DEBOUNCE_CYCLES(N), .CNT_W(CNT_W), .ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .reset(reset),
    .btn_sig_raw(press_n[0]), .btn_reg_raw(press_n[1]), .btn_can_raw(press_n[2]),
    .siguiente(sig_l), .regresar(reg_l), .cancelar(can_l), .pending(pend_l)
  );

  // Scoreboard counters
  int compared = 0;
  int mism     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mism++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model
  logic [2:0] m_s1, m_s2, m_stable, m_pend, m_pulse;
  int         m_hist [3][$];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0; m_pulse = '0;
    for (int c = 0; c < 3; c++) m_hist[c].delete();
  endtask

  task automatic model_edge(input logic [2:0] p);
    logic [2:0] acc;
    logic [2:0] grant;
    bit         all_diff;
    acc   = '0;
    grant = '0;
    for (int c = 2; c >= 0; c--) begin
      if (m_pend[c] && grant == 3'b000) grant[c] = 1'b1;
    end
    for (int c = 0; c < 3; c++) begin
      m_hist[c].push_back(int'(m_s2[c]));
      if (m_hist[c].size() > N) void'(m_hist[c].pop_front());
      all_diff = (m_hist[c].size() == N);
      for (int k = 0; k < m_hist[c].size(); k++) begin
        if (m_hist[c][k] == int'(m_stable[c])) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_stable[c] = ~m_stable[c];
        m_hist[c].delete();
        if (m_stable[c]) acc[c] = 1'b1;
      end
    end
    m_pend  = (m_pend & ~grant) | acc;
    m_pulse = grant;
    m_s2    = m_s1;
    m_s1    = p;
  endtask

  // Per-phase statistics
  int         cyc_idx;
  int         n_p [3];
  int         first_idx [3];
  int         n_sig_l;
  int         max_cnt = 0;
  logic [2:0] pend_log [64];

  task automatic clear_stats();
    cyc_idx = 0;
    n_sig_l = 0;
    for (int c = 0; c < 3; c++) begin
      n_p[c] = 0;
      first_idx[c] = -1;
    end
  endtask

  // Driver: present one input vector for one clock, then check both DUTs.
  task automatic cycle(input logic [2:0] p);
    logic [2:0] obs;
    press = p;
    @(posedge clk);
    model_edge(p);
    #1;
    chk("pulse_h", 32'({can_h, reg_h, sig_h}), 32'(m_pulse));
    chk("pulse_l", 32'({can_l, reg_l, sig_l}), 32'(m_pulse));
    chk("pend_h", 32'(pend_h), 32'(m_pend));
    chk("pend_l", 32'(pend_l), 32'(m_pend));
    obs = {can_h, reg_h, sig_h};
    for (int c = 0; c < 3; c++) begin
      if (obs[c]) begin
        n_p[c]++;
        if (first_idx[c] < 0) first_idx[c] = cyc_idx;
      end
      if (int'(dut_h.r_cnt[c]) > max_cnt) max_cnt = int'(dut_h.r_cnt[c]);
      if (int'(dut_l.r_cnt[c]) > max_cnt) max_cnt = int'(dut_l.r_cnt[c]);
    end
    if (sig_l) n_sig_l++;
    if (cyc_idx < 64) pend_log[cyc_idx] = pend_h;
    cyc_idx++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(3'b000);
  endtask

  logic [2:0] rp;
  int         hold;
  logic [5:0] bounce;

  initial begin
    model_reset();
    clear_stats();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pulse_h", 32'({can_h, reg_h, sig_h}), 32'd0);
    chk("rst_pulse_l", 32'({can_l, reg_l, sig_l}), 32'd0);
    chk("rst_pend_h", 32'(pend_h), 32'd0);
    chk("rst_pend_l", 32'(pend_l), 32'd0);
    reset = 1'b0;
    idle(10);

    // Clean press on next, held 20 cycles, then released
    clear_stats();
    repeat (20) cycle(3'b001);
    chk("clean_sig_count", 32'(n_p[0]), 32'd1);
    chk("clean_sig_index", 32'(first_idx[0]), 32'd6);
    chk("clean_reg_count", 32'(n_p[1]), 32'd0);
    chk("clean_can_count", 32'(n_p[2]), 32'd0);
    clear_stats();
    idle(15);
    chk("clean_release_pulses", 32'(n_p[0] + n_p[1] + n_p[2]), 32'd0);

    // Bounce on back: 1,0,1,1,0,1 then held
    clear_stats();
    bounce = 6'b101101;
    for (int k = 0; k < 6; k++) cycle({1'b0, bounce[5-k], 1'b0});
    repeat (14) cycle(3'b010);
    chk("bounce_reg_count", 32'(n_p[1]), 32'd1);
    chk("bounce_reg_index", 32'(first_idx[1]), 32'd11);
    idle(15);

    // All three pressed on the same cycle
    clear_stats();
    repeat (12) cycle(3'b111);
    chk("simul_pend_5", 32'(pend_log[5]), 32'b111);
    chk("simul_pend_6", 32'(pend_log[6]), 32'b011);
    chk("simul_pend_7", 32'(pend_log[7]), 32'b001);
    chk("simul_pend_8", 32'(pend_log[8]), 32'b000);
    chk("simul_can_index", 32'(first_idx[2]), 32'd6);
    chk("simul_reg_index", 32'(first_idx[1]), 32'd7);
    chk("simul_sig_index", 32'(first_idx[0]), 32'd8);
    idle(15);

    // Active-low instance: idle high, pulled low for 10 cycles, released
    clear_stats();
    repeat (10) cycle(3'b001);
    chk("polarity_press_pulses", 32'(n_sig_l), 32'd1);
    clear_stats();
    idle(15);
    chk("polarity_release_pulses", 32'(n_sig_l), 32'd0);

    // Reset while pending = 110, buttons kept held
    clear_stats();
    repeat (6) cycle(3'b110);
    chk("midrst_pend_before", 32'(pend_h), 32'b110);
    reset = 1'b1;
    #1;
    chk("midrst_pulse_h", 32'({can_h, reg_h, sig_h}), 32'd0);
    chk("midrst_pulse_l", 32'({can_l, reg_l, sig_l}), 32'd0);
    chk("midrst_pend_h", 32'(pend_h), 32'd0);
    chk("midrst_pend_l", 32'(pend_l), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_stats();
    repeat (12) cycle(3'b110);
    chk("midrst_can_count", 32'(n_p[2]), 32'd1);
    chk("midrst_can_index", 32'(first_idx[2]), 32'(N + 2));
    chk("midrst_reg_count", 32'(n_p[1]), 32'd1);
    chk("midrst_reg_index", 32'(first_idx[1]), 32'(N + 3));
    chk("midrst_sig_count", 32'(n_p[0]), 32'd0);
    idle(15);

    // Long hold
    clear_stats();
    repeat (1000) cycle(3'b001);
    chk("long_sig_count", 32'(n_p[0]), 32'd1);
    idle(15);

    // Random bouncing traffic against the model
    for (int k = 0; k < 80; k++) begin
      rp   = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 8);
      repeat (hold) cycle(rp);
    end
    idle(20);

    chk("cnt_never_exceeds_n_minus_1", 32'(max_cnt <= N - 1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
